// File: rtl/boot_pkg.sv
// Shared types and constants for the imem boot loader: FSM state encoding and header size.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } boot_state_e;

    localparam int BOOT_HDR_BYTES = 2;

    // True while the loader owns the imem address (word index instead of core PC)
    function automatic logic is_load_state(input boot_state_e s);
        logic r;
        case (s)
            LEN, DATA, WRITE: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Little-endian 8->32 packer: byte0 lands in [7:0], byte3 in [31:24]; word_valid flags the 4th byte.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shreg_r;
    logic [1:0]  byte_cnt_r;

    // Combinational view of the completed word, valid together with the 4th byte
    always_comb begin
        word       = {byte_data, shreg_r};
        word_valid = byte_valid & (byte_cnt_r == 2'd3);
    end

    // Byte shift register and byte position counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r    <= 24'h00_0000;
            byte_cnt_r <= 2'd0;
        end else if (clear) begin
            shreg_r    <= 24'h00_0000;
            byte_cnt_r <= 2'd0;
        end else if (byte_valid) begin
            shreg_r    <= {byte_data, shreg_r[23:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader owning the imem write port: length header, little-endian word assembly,
// imem writes, then release of the core reset with imem address handed to the core PC.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] cpu_pc,
    output logic [31:0] imem_pc,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int WIDX  = $clog2(DEPTH) + 1;
    localparam int HDR_W = (BOOT_HDR_BYTES > 1) ? $clog2(BOOT_HDR_BYTES) : 1;
    localparam logic [HDR_W-1:0] HDR_LAST  = HDR_W'(BOOT_HDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [WIDX-1:0]  DEPTH_IDX = WIDX'(DEPTH);

    boot_state_e       state_r, next_state_s;
    logic [HDR_W-1:0]  hdr_cnt_r;
    logic [7:0]        len_lo_r;
    logic [WIDX-1:0]   word_idx_r;
    logic [WIDX-1:0]   target_r;
    logic [WIDX-1:0]   word_idx_inc_s;
    logic [CNT_W-1:0]  hdr_count_s;
    logic              rx_fire_s;
    logic              start_ok_s;
    logic              hdr_last_s;
    logic              word_valid_s;
    logic [31:0]       word_s;

    logic              rx_ready_r;
    logic              imem_we_r;
    logic [31:0]       imem_wdata_r;
    logic              cpu_rst_n_r;
    logic              busy_r;
    logic              done_r;
    logic              overflow_r;

    // Transfer qualifiers and header assembly; rx_ready comes straight from a flop
    always_comb begin
        rx_fire_s      = rx_valid & rx_ready_r;
        start_ok_s     = start & ((state_r == IDLE) || (state_r == DONE));
        hdr_last_s     = (hdr_cnt_r == HDR_LAST);
        hdr_count_s    = CNT_W'({rx_data, len_lo_r});
        word_idx_inc_s = word_idx_r + WIDX'(1);
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok_s),
        .byte_valid (rx_fire_s & (state_r == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = LEN;
                else       next_state_s = IDLE;
            end
            LEN: begin
                if (rx_fire_s && hdr_last_s) begin
                    if (hdr_count_s == {CNT_W{1'b0}}) next_state_s = DONE;
                    else                             next_state_s = DATA;
                end else begin
                    next_state_s = LEN;
                end
            end
            DATA: begin
                if (word_valid_s) next_state_s = WRITE;
                else              next_state_s = DATA;
            end
            WRITE: begin
                if (word_idx_inc_s == target_r) next_state_s = DONE;
                else                            next_state_s = DATA;
            end
            DONE: begin
                if (start) next_state_s = LEN;
                else       next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Header, target clamp and word index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt_r  <= {HDR_W{1'b0}};
            len_lo_r   <= 8'h00;
            word_idx_r <= {WIDX{1'b0}};
            target_r   <= {WIDX{1'b0}};
            overflow_r <= 1'b0;
        end else if (start_ok_s) begin
            hdr_cnt_r  <= {HDR_W{1'b0}};
            len_lo_r   <= 8'h00;
            word_idx_r <= {WIDX{1'b0}};
            target_r   <= {WIDX{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if ((state_r == LEN) && rx_fire_s) begin
                if (hdr_last_s) begin
                    hdr_cnt_r <= {HDR_W{1'b0}};
                    if (hdr_count_s > DEPTH_CNT) begin
                        overflow_r <= 1'b1;
                        target_r   <= DEPTH_IDX;
                    end else begin
                        target_r   <= WIDX'(hdr_count_s);
                    end
                end else begin
                    len_lo_r  <= rx_data;
                    hdr_cnt_r <= hdr_cnt_r + HDR_W'(1);
                end
            end
            if (state_r == WRITE) word_idx_r <= word_idx_inc_s;
        end
    end

    // Registered outputs decoded from the upcoming state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_wdata_r <= 32'h0000_0000;
            cpu_rst_n_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            rx_ready_r  <= (next_state_s == LEN) || (next_state_s == DATA);
            imem_we_r   <= (next_state_s == WRITE);
            cpu_rst_n_r <= (next_state_s == DONE);
            done_r      <= (next_state_s == DONE);
            busy_r      <= is_load_state(next_state_s);
            if (word_valid_s) imem_wdata_r <= word_s;
        end
    end

    // imem address: loader word index while loading, core PC otherwise
    always_comb begin
        if (is_load_state(state_r)) imem_pc = 32'(word_idx_r);
        else                        imem_pc = cpu_pc;
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst_n  = cpu_rst_n_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: small image, empty image, clamped image,
// gappy byte stream, reset mid-load and reload from DONE.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] cpu_pc = 32'h0000_0100;
    logic [31:0] imem_pc;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        overflow;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          wr_cnt  = 0;
    logic [31:0] wr_idx  [0:511];
    logic [31:0] wr_data [0:511];

    imem_boot_loader #(.DEPTH(64), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cpu_pc     (cpu_pc),
        .imem_pc    (imem_pc),
        .imem_we    (imem_we),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_idx[wr_cnt]  = imem_pc;
            wr_data[wr_cnt] = imem_wdata;
            wr_cnt          = wr_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte (after optional idle gap) and hold it until accepted; returns on the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        cmp_cnt++;
        assert (ok === 1'b1) else begin
            err_cnt++;
            $error("FAIL rx_accept: observed %b expected 1 (byte %h)", ok, b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    initial begin
        int base;
        int bad;
        logic [31:0] w;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rx_ready",  32'(rx_ready),  32'h0);
        check("rst_imem_we",   32'(imem_we),   32'h0);
        check("rst_wdata",     imem_wdata,     32'h0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("rst_busy_done_ovf", {29'h0, busy, done, overflow}, 32'h0);
        check("rst_imem_pc",   imem_pc,        32'h0000_0100);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'h0);

        // 3-word image, back-to-back bytes
        pulse_start();
        check("t1_busy", {30'h0, busy, rx_ready}, 32'h3);
        base = wr_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        check("t1_pc_load", imem_pc, 32'h0);
        send_word(32'h0000_0013, 0);
        check("t1_we0",      {30'h0, imem_we, rx_ready}, 32'h2);
        check("t1_wdata0",   imem_wdata, 32'h0000_0013);
        send_word(32'h0010_0093, 0);
        send_word(32'h0000_006F, 0);
        check("t1_we2",      32'(imem_we), 32'h1);
        check("t1_pc2",      imem_pc, 32'h2);
        check("t1_wdata2",   imem_wdata, 32'h0000_006F);
        check("t1_done_pre", 32'(done), 32'h0);
        @(negedge clk);
        check("t1_done",     {28'h0, done, cpu_rst_n, imem_we, busy}, 32'hC);
        check("t1_nwr",      32'(wr_cnt - base), 32'h3);
        check("t1_idx0",     wr_idx[base],     32'h0);
        check("t1_dat0",     wr_data[base],    32'h0000_0013);
        check("t1_idx1",     wr_idx[base+1],   32'h1);
        check("t1_dat1",     wr_data[base+1],  32'h0010_0093);
        check("t1_idx2",     wr_idx[base+2],   32'h2);
        check("t1_dat2",     wr_data[base+2],  32'h0000_006F);
        cpu_pc = 32'h0000_0008;
        #1;
        check("t1_pc_run",   imem_pc, 32'h0000_0008);

        // 80-word header clamps to 64 writes
        @(negedge clk);
        pulse_start();
        base = wr_cnt;
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        check("ovf_flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 64; i++) begin
            w = {8'hC0, 8'h22, 8'h11, 8'(i)};
            send_word(w, 0);
        end
        @(negedge clk);
        check("ovf_done", {29'h0, done, overflow, rx_ready}, 32'h6);
        check("ovf_nwr",  32'(wr_cnt - base), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            w = {8'hC0, 8'h22, 8'h11, 8'(i)};
            if (wr_idx[base+i] !== 32'(i) || wr_data[base+i] !== w) bad++;
        end
        check("ovf_words", 32'(bad), 32'h0);

        // Reload from DONE clears overflow and re-asserts core reset; then empty image
        pulse_start();
        check("rl_flags", {28'h0, cpu_rst_n, done, busy, overflow}, 32'h2);
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("empty_done", {29'h0, done, cpu_rst_n, busy}, 32'h6);
        @(negedge clk);
        check("empty_nwr", 32'(wr_cnt - base), 32'h0);

        // Gappy stream: rx_valid drops randomly between bytes
        pulse_start();
        base = wr_cnt;
        send_byte(8'h03, 2);
        send_byte(8'h00, 1);
        send_word(32'hDEAD_BEEF, 3);
        send_word(32'h0123_4567, 3);
        send_word(32'hA5A5_5A5A, 3);
        @(negedge clk);
        check("gap_done", 32'(done), 32'h1);
        check("gap_nwr",  32'(wr_cnt - base), 32'h3);
        check("gap_dat0", wr_data[base],   32'hDEAD_BEEF);
        check("gap_dat1", wr_data[base+1], 32'h0123_4567);
        check("gap_dat2", wr_data[base+2], 32'hA5A5_5A5A);
        check("gap_idx2", wr_idx[base+2],  32'h2);

        // Async reset after 6 bytes of a 2-word image, then full reload
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        cpu_pc = 32'h0000_0040;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_outs", {26'h0, rx_ready, imem_we, cpu_rst_n, busy, done, overflow}, 32'h0);
        check("ar_wdata", imem_wdata, 32'h0);
        check("ar_pc",    imem_pc,    32'h0000_0040);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        base = wr_cnt;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'hDDCC_BBAA, 0);
        send_word(32'h0403_0201, 0);
        @(negedge clk);
        check("ar2_done", {30'h0, done, cpu_rst_n}, 32'h3);
        check("ar2_nwr",  32'(wr_cnt - base), 32'h2);
        check("ar2_dat0", wr_data[base],   32'hDDCC_BBAA);
        check("ar2_dat1", wr_data[base+1], 32'h0403_0201);
        check("ar2_idx1", wr_idx[base+1],  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
